// File: rtl/ehl_gpio_debounce.sv
// Per-pin pad input conditioning: synchroniser, prescaled glitch filter and
// registered rise/fall edge pulses feeding the GPIO core.
module ehl_gpio_debounce #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 4,
  parameter int               PRE_W       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] filt_ena,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] threshold,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;
  logic [CNT_W-1:0] thr_m1;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] gpio_q, gpio_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mism;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // '>=' rather than '==' so a prescale lowered below the running count
  // still produces a tick on the next clock instead of waiting for a wrap.
  assign tick      = (pre_cnt_q >= prescale);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

  // Compare against threshold-1 so a threshold of 0 behaves like 1.
  assign thr_m1 = (threshold == '0) ? '0 : threshold - CNT_W'(1);
  assign mism   = sync_s ^ gpio_q;

  always_comb begin
    gpio_d = gpio_q;
    for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];
    for (int i = 0; i < WIDTH; i++) begin
      if (!filt_ena[i]) begin
        gpio_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else if (!mism[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] >= thr_m1) begin
          gpio_d[i] = sync_s[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise_d = ~gpio_q & gpio_d;
  assign fall_d = gpio_q & ~gpio_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      gpio_q    <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      gpio_q    <= gpio_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpio_in = gpio_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule
